// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage around an external word-addressed PC register.
//   Picks the PC register's next value (reset, branch, jump, hold or sequential),
//   drives the instruction-memory address, and captures the fetched instruction
//   into the IF/ID pipeline register. It also keeps a saturating count of the
//   bubbles it inserts.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   pc_in / next_pc     PC register output / PC register input (combinational)
//   imem_addr/imem_data instruction memory word address / asynchronous read data
//   stall, flush        hazard hold / control squash of IF/ID
//   br_taken, br_target EX-stage taken branch and its word target
//   jump, jump_index    ID-stage jump and its 26-bit index field
//   if_id_*             registered instruction, pc+1 and valid
//   bubble_cnt          saturating count of bubbles loaded into IF/ID
module if_fetch_stage #(
    parameter int unsigned ADDR_W   = 30,
    parameter int unsigned INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  next_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_plus1,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam int unsigned JIDX_W = 26;

    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_plus1;
    logic               r_valid;
    logic [CNT_W-1:0]   r_bubble_cnt;

    logic [ADDR_W-1:0]  w_pc_plus1;
    logic [ADDR_W-1:0]  w_jump_target;
    logic               w_jump_go;
    logic               w_load_bubble;

    // Sequential PC wraps silently at the top of the word address space.
    assign w_pc_plus1    = pc_in + ADDR_W'(1);
    // Jump keeps the region bits of the instruction now sitting in ID.
    assign w_jump_target = {r_pc_plus1[ADDR_W-1:JIDX_W], jump_index};
    // A stalled ID stage cannot act on its jump; it is presented again next cycle.
    assign w_jump_go     = jump && !stall;
    assign w_load_bubble = br_taken || flush || w_jump_go;

    assign imem_addr = pc_in;

    // Next-PC select, highest priority first.
    always_comb begin
        next_pc = w_pc_plus1;
        if (!reset) begin
            next_pc = RESET_PC;
        end else if (br_taken) begin
            next_pc = br_target;
        end else if (w_jump_go) begin
            next_pc = w_jump_target;
        end else if (stall) begin
            next_pc = pc_in;
        end
    end

    // IF/ID register and bubble counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_instr      <= '0;
            r_pc_plus1   <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (w_load_bubble) begin
            r_instr    <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
            if (r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (!stall) begin
            r_instr    <= imem_data;
            r_pc_plus1 <= w_pc_plus1;
            r_valid    <= 1'b1;
        end
    end

    assign if_id_instr    = r_instr;
    assign if_id_pc_plus1 = r_pc_plus1;
    assign if_id_valid    = r_valid;
    assign bubble_cnt     = r_bubble_cnt;

endmodule
